exec_unit: RTL and testbench

Multi-cycle 8-bit execute stage that sits directly downstream of the register file read ports and upstream of its write port. Operands are presented from the register file read data outputs. The block runs single-cycle logic ops, iterative shifts, and an iterative 8x8 multiply. It drives the register file write port (data, address, enable) for exactly one cycle per completed operation.

---
 rtl/exec_unit.sv | 204 ++++++++++++++++++++
 tb/tb_exec_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// exec_unit: multi-cycle 8-bit execute stage between register file read and write ports.
// Runs single-cycle logic/arith ops, bit-serial shifts and an 8-cycle shift-add multiply.
// Drives the write port for exactly one cycle (WB) per completed operation.
module exec_unit #(
  parameter int pw = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [pw-1:0] dst,
  input  logic [7:0]    opA,
  input  logic [7:0]    opB,
  output logic          busy,
  output logic          done,
  output logic          wr_en,
  output logic [pw-1:0] wr_addr,
  output logic [7:0]    dat_out,
  output logic          carry
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  state_e        state_q;
  op_e           op_q;
  logic [pw-1:0] dst_q;
  logic [15:0]   work_q;    // shift operand (low byte) or multiplicand (full width)
  logic [7:0]    mplier_q;  // multiplier, consumed LSB first
  logic [15:0]   prod_q;    // partial product
  logic [3:0]    cnt_q;     // remaining RUN iterations
  logic [pw-1:0] addr_q;
  logic [7:0]    dat_q;
  logic          carry_q;

  // Operand decode for the IDLE-cycle capture
  op_e        op_in;
  logic [8:0] sum9;
  logic [2:0] shamt;

  // One RUN iteration of the shift and multiply datapaths
  logic [7:0]  shl_val;
  logic        shl_out;
  logic [7:0]  shr_val;
  logic        shr_out;
  logic [15:0] prod_d;
  logic        last_iter;

  // Combinational next-iteration values; every output gets a default first.
  // NOTE: assigning a default to every always_comb output before any branch is what keeps it latch-free.
  always_comb begin
    op_in     = op_e'(op);
    sum9      = {1'b0, opA} + {1'b0, opB};
    shamt     = opB[2:0];
    shl_val   = {work_q[6:0], 1'b0};
    shl_out   = work_q[7];
    shr_val   = {1'b0, work_q[7:1]};
    shr_out   = work_q[0];
    prod_d    = prod_q;
    if (mplier_q[0]) begin
      prod_d = prod_q + work_q;
    end
    last_iter = (cnt_q == 4'd1);
  end

  // Control FSM plus datapath registers; results land in the output registers on entry to WB.
  // NOTE: every register here uses <= so all updates within a cycle see the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      dst_q    <= '0;
      work_q   <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      dat_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q     <= op_in;
            dst_q    <= dst;
            work_q   <= {8'h00, opA};
            mplier_q <= opB;
            prod_q   <= '0;
            cnt_q    <= '0;
            case (op_in)
              OP_ADD: begin
                dat_q   <= sum9[7:0];
                carry_q <= sum9[8];
                addr_q  <= dst;
                state_q <= WB;
              end
              OP_SUB: begin
                dat_q   <= opA - opB;
                carry_q <= (opA >= opB);
                addr_q  <= dst;
                state_q <= WB;
              end
              OP_AND: begin
                dat_q   <= opA & opB;
                addr_q  <= dst;
                state_q <= WB;
              end
              OP_XOR: begin
                dat_q   <= opA ^ opB;
                addr_q  <= dst;
                state_q <= WB;
              end
              OP_CMP: begin
                // Compare writes only the flag; dat_out keeps its previous value.
                carry_q <= (opA == opB);
                addr_q  <= dst;
                state_q <= WB;
              end
              OP_SHL, OP_SHR: begin
                if (shamt == 3'd0) begin
                  dat_q   <= opA;
                  carry_q <= 1'b0;
                  addr_q  <= dst;
                  state_q <= WB;
                end else begin
                  cnt_q   <= {1'b0, shamt};
                  state_q <= RUN;
                end
              end
              OP_MUL: begin
                cnt_q   <= 4'd8;
                state_q <= RUN;
              end
              default: state_q <= IDLE;
            endcase
          end
        end

        RUN: begin
          cnt_q <= cnt_q - 4'd1;
          case (op_q)
            OP_SHL: begin
              work_q <= {8'h00, shl_val};
              if (last_iter) begin
                dat_q   <= shl_val;
                carry_q <= shl_out;
              end
            end
            OP_SHR: begin
              work_q <= {8'h00, shr_val};
              if (last_iter) begin
                dat_q   <= shr_val;
                carry_q <= shr_out;
              end
            end
            OP_MUL: begin
              prod_q   <= prod_d;
              work_q   <= {work_q[14:0], 1'b0};
              mplier_q <= {1'b0, mplier_q[7:1]};
              if (last_iter) begin
                dat_q   <= prod_d[7:0];
                carry_q <= |prod_d[15:8];
              end
            end
            default: ;
          endcase
          if (last_iter) begin
            addr_q  <= dst_q;
            state_q <= WB;
          end
        end

        WB: begin
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Status and write strobe are decoded straight from the state register.
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == WB);
  assign wr_en   = (state_q == WB) && (op_q != OP_CMP);
  assign wr_addr = addr_q;
  assign dat_out = dat_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: a reference model pushes expected write-back
// results into a queue at issue time; they are popped and compared at WB.
module tb_exec_unit;

  localparam int PW = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [PW-1:0] dst;
  logic [7:0]    opA;
  logic [7:0]    opB;
  logic          busy;
  logic          done;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [7:0]    dat_out;
  logic          carry;

  exec_unit #(.pw(PW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .dst     (dst),
    .opA     (opA),
    .opB     (opB),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .dat_out (dat_out),
    .carry   (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [PW-1:0] dst;
    logic [7:0]    dat;
    logic          c;
    logic          wr;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] m_dat;
  logic       m_c;
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Compute the expected WB result, optionally queue it, and drive the request.
  task automatic begin_op(input logic [2:0] o, input logic [PW-1:0] d,
                          input logic [7:0] a, input logic [7:0] b, input bit push);
    exp_t e;
    logic [15:0] t;
    int n;
    n     = int'(b[2:0]);
    e.op  = o;
    e.dst = d;
    e.dat = m_dat;
    e.c   = m_c;
    e.wr  = 1'b1;
    e.lat = 1;
    case (o)
      3'd0: begin t = {8'h00, a} + {8'h00, b}; e.dat = t[7:0]; e.c = t[8]; end
      3'd1: begin e.dat = a - b; e.c = (a >= b); end
      3'd2: e.dat = a & b;
      3'd3: e.dat = a ^ b;
      3'd4: begin t = {8'h00, a} << n; e.dat = t[7:0]; e.c = t[8]; e.lat = n + 1; end
      3'd5: begin t = {a, 8'h00} >> n; e.dat = t[15:8]; e.c = t[7]; e.lat = n + 1; end
      3'd6: begin t = {8'h00, a} * {8'h00, b}; e.dat = t[7:0]; e.c = |t[15:8]; e.lat = 9; end
      default: begin e.c = (a == b); e.wr = 1'b0; end
    endcase
    if (push) begin
      exp_q.push_back(e);
      m_dat = e.dat;
      m_c   = e.c;
    end
    start = 1'b1;
    op    = o;
    dst   = d;
    opA   = a;
    opB   = b;
  endtask

  task automatic launch();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called #1 into cycle 1; walks the bounded latency window and checks WB.
  // With inject set, an ADD request is held on start from cycle 3 onward.
  task automatic wait_wb(input bit inject);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    for (int k = 1; k <= e.lat; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (inject && k == 3) begin
        start = 1'b1; op = 3'd0; dst = 3'd5; opA = 8'h01; opB = 8'h02;
      end
      @(negedge clk);
      if (k < e.lat) begin
        check($sformatf("run_ctl op%0d c%0d", e.op, k), {busy, done, wr_en}, 3'b100);
      end else begin
        check($sformatf("wb_ctl op%0d", e.op), {busy, done, wr_en}, {2'b11, e.wr});
        check($sformatf("wb_addr op%0d", e.op), wr_addr, e.dst);
        check($sformatf("wb_dat op%0d", e.op), dat_out, e.dat);
        check($sformatf("wb_carry op%0d", e.op), carry, e.c);
      end
    end
    @(negedge clk);
    check($sformatf("post_wb op%0d", e.op), {busy, done, wr_en}, 3'b000);
    check($sformatf("hold_dat op%0d", e.op), dat_out, e.dat);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [PW-1:0] d,
                        input logic [7:0] a, input logic [7:0] b);
    begin_op(o, d, a, b, 1'b1);
    launch();
    wait_wb(1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_dat    = 8'h00;
    m_c      = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 3'd0;
    dst      = '0;
    opA      = 8'h00;
    opB      = 8'h00;

    #12;
    check("reset_outs", {busy, done, wr_en, wr_addr, dat_out, carry}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 3'd2, 8'hF0, 8'h20);   // ADD -> 0x10, carry 1
    run_op(3'd5, 3'd1, 8'h81, 8'h01);   // SHR 1 -> 0x40, carry 1
    run_op(3'd4, 3'd3, 8'h81, 8'h03);   // SHL 3 -> 0x08, carry 0
    run_op(3'd4, 3'd4, 8'hA5, 8'h08);   // SHL n=0 -> A, carry 0

    // MUL with an ADD request held during cycles 3..9; ADD accepted in cycle 10.
    begin_op(3'd6, 3'd6, 8'h13, 8'h11, 1'b1);
    launch();
    wait_wb(1'b1);
    begin_op(3'd0, 3'd5, 8'h01, 8'h02, 1'b1);
    launch();
    wait_wb(1'b0);

    run_op(3'd7, 3'd0, 8'h55, 8'h55);   // CMP equal: carry 1
    run_op(3'd7, 3'd0, 8'h55, 8'h54);   // CMP unequal: carry 0, dat unchanged
    run_op(3'd1, 3'd7, 8'h10, 8'h20);   // SUB borrow: carry 0
    run_op(3'd1, 3'd7, 8'h20, 8'h20);   // SUB equal: carry 1
    run_op(3'd2, 3'd1, 8'hCC, 8'hAA);   // AND: carry kept
    run_op(3'd3, 3'd2, 8'hCC, 8'hAA);   // XOR: carry kept
    run_op(3'd6, 3'd3, 8'hFF, 8'hFF);   // MUL max
    run_op(3'd5, 3'd4, 8'hFF, 8'h07);   // SHR 7

    for (int i = 0; i < 24; i++) begin
      run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // Asynchronous reset in the middle of a multiply: result discarded.
    begin_op(3'd6, 3'd3, 8'h13, 8'h11, 1'b0);
    launch();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_rst_outs", {busy, done, wr_en, wr_addr, dat_out, carry}, 32'd0);
    m_dat = 8'h00;
    m_c   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_wr_after_rst", {busy, wr_en}, 2'b00);
    end

    run_op(3'd0, 3'd1, 8'h01, 8'h01);   // ADD -> 0x02 in cycle 1

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
